reg5_scan_reader: RTL and testbench

- Read-side companion to the bank of 5-bit enable-write registers.
- Walks a bank of NREGS 5-bit registers through an external read mux and keeps a shadow copy of each.
- Whenever a register's value differs from its shadow, emits an {index, value} change event on a valid/ready port to the game-control logic.
- Lets consumers react to piece/position register updates without polling every register.

---
 rtl/reg5_scan_reader.sv | 100 ++++++++++
 tb/tb_reg5_scan_reader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg5_scan_reader.sv
// rtl/reg5_scan_reader.sv - scans a bank of 5-bit registers and emits {index, value} change events
// Keeps a shadow copy per register; any mismatch or invalid shadow produces one handshaken event.
module reg5_scan_reader #(
    parameter int NREGS = 8,
    parameter int IDXW  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            scan_en,
    input  logic            force_all,
    output logic [IDXW-1:0] rd_sel,
    input  logic [4:0]      rd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_idx,
    output logic [4:0]      out_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_HOLD
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREGS - 1);

    state_t          state_q;
    logic [IDXW-1:0] sel_q;
    logic            valid_q;
    logic [IDXW-1:0] idx_q;
    logic [4:0]      data_q;
    logic [4:0]      shadow_q [NREGS];
    logic [NREGS-1:0] shv_q;

    logic [IDXW-1:0] sel_inc_d;
    logic            changed_d;

    // rd_sel must never leave 0..NREGS-1, so the increment wraps explicitly
    always_comb begin
        sel_inc_d = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
        changed_d = !shv_q[sel_q] || (rd_data != shadow_q[sel_q]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            shv_q   <= '0;
            for (int i = 0; i < NREGS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_en) begin
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!scan_en) begin
                        state_q <= ST_IDLE;
                    end else if (changed_d) begin
                        idx_q            <= sel_q;
                        data_q           <= rd_data;
                        shadow_q[sel_q]  <= rd_data;
                        shv_q[sel_q]     <= 1'b1;
                        valid_q          <= 1'b1;
                        state_q          <= ST_HOLD;
                    end else begin
                        sel_q <= sel_inc_d;
                    end
                end
                ST_HOLD: begin
                    // scan_en is only consulted once the event has been taken
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        sel_q   <= sel_inc_d;
                        state_q <= scan_en ? ST_SCAN : ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            // Placed last so it overrides a same-cycle detection's valid bit
            if (force_all) begin
                shv_q <= '0;
            end
        end
    end

    assign rd_sel    = sel_q;
    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_reg5_scan_reader.sv
// tb/tb_reg5_scan_reader.sv - directed self-checking bench for reg5_scan_reader
module tb_reg5_scan_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       scan_en;
    logic       force_all;
    logic [2:0] rd_sel;
    logic [4:0] rd_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic [4:0] out_data;

    logic [4:0] bank [8];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rd_data = bank[rd_sel];

    reg5_scan_reader #(.NREGS(8), .IDXW(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .scan_en   (scan_en),
        .force_all (force_all),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; waits for out_valid, checks it, then steps past the accepting edge.
    task automatic expect_event(input string tag, input int idx, input int data, input int budget);
        for (int i = 0; i < budget && !out_valid; i++) @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_idx"}, 32'(out_idx), 32'(idx));
        check({tag, "_data"}, 32'(out_data), 32'(data));
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget && !out_valid; i++) @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    task automatic expect_pass(input string tag, input int start, input logic [4:0] vals [8]);
        for (int k = 0; k < 8; k++) begin
            int ix;
            ix = (start + k) % 8;
            expect_event($sformatf("%s%0d", tag, ix), ix, int'(vals[ix]), 12);
        end
    endtask

    initial begin
        logic       stable;
        logic [2:0] hold_idx;
        logic [4:0] hold_data;
        logic [4:0] exp_bank [8];

        reset     = 1'b0;
        scan_en   = 1'b1;
        force_all = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) bank[i] = 5'(i);

        repeat (2) @(negedge clk);
        check("rst_rd_sel", 32'(rd_sel), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);

        // Power-up sync: every register reported once, in order
        reset = 1'b1;
        for (int i = 0; i < 8; i++) exp_bank[i] = 5'(i);
        expect_pass("sync", 0, exp_bank);
        expect_quiet("sync_quiet", 50);

        // Single change
        bank[5] = 5'h1F;
        expect_event("single5", 5, 5'h1F, 10);
        expect_quiet("single_quiet", 20);

        // Backpressure with a second change arriving while held
        out_ready = 1'b0;
        bank[6] = 5'd9;
        wait_valid("bp_pend", 12);
        hold_idx  = out_idx;
        hold_data = out_data;
        check("bp_idx", 32'(hold_idx), 32'd6);
        check("bp_data", 32'(hold_data), 32'd9);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) bank[2] = 5'd3;
            if (i == 12) bank[2] = 5'd4;
            @(negedge clk);
            if (!out_valid || out_idx != hold_idx || out_data != hold_data) stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        out_ready = 1'b1;
        expect_event("bp_rel6", 6, 9, 2);
        expect_event("bp_reg2", 2, 4, 10);
        expect_quiet("bp_quiet", 20);

        // scan_en dropped in SCAN at rd_sel=7, then re-enabled
        for (int i = 0; i < 10 && rd_sel != 3'd7; i++) @(negedge clk);
        check("wrap_at7", 32'(rd_sel), 32'd7);
        scan_en = 1'b0;
        repeat (3) @(negedge clk);
        check("wrap_held7", 32'(rd_sel), 32'd7);
        scan_en = 1'b1;
        @(negedge clk);
        check("wrap_idle2scan", 32'(rd_sel), 32'd7);
        @(negedge clk);
        check("wrap_to0", 32'(rd_sel), 32'd0);

        // scan_en dropped while an event is held
        out_ready = 1'b0;
        bank[1] = 5'd20;
        wait_valid("hs_pend", 12);
        scan_en = 1'b0;
        repeat (3) @(negedge clk);
        check("hs_still_valid", 32'(out_valid), 32'd1);
        check("hs_idx", 32'(out_idx), 32'd1);
        out_ready = 1'b1;
        expect_event("hs_done", 1, 20, 2);
        check("hs_idle_sel", 32'(rd_sel), 32'd2);
        expect_quiet("hs_idle_quiet", 4);
        check("hs_idle_sel_held", 32'(rd_sel), 32'd2);

        // force_all from IDLE: full re-report starting at rd_sel=2
        scan_en   = 1'b1;
        force_all = 1'b1;
        @(negedge clk);
        force_all = 1'b0;
        exp_bank = '{5'd0, 5'd20, 5'd4, 5'd3, 5'd4, 5'h1F, 5'd9, 5'd7};
        expect_pass("force", 2, exp_bank);
        expect_quiet("force_quiet", 20);

        // force_all while holding the event for idx 3
        out_ready = 1'b0;
        bank[3] = 5'd11;
        exp_bank[3] = 5'd11;
        wait_valid("fh_pend", 12);
        check("fh_idx", 32'(out_idx), 32'd3);
        force_all = 1'b1;
        @(negedge clk);
        force_all = 1'b0;
        check("fh_kept", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        expect_event("fh_done", 3, 11, 2);
        expect_pass("fh_pass", 4, exp_bank);
        expect_quiet("fh_quiet", 20);

        // Asynchronous reset between edges while holding
        out_ready = 1'b0;
        bank[0] = 5'd17;
        exp_bank[0] = 5'd17;
        wait_valid("ar_pend", 12);
        #2 reset = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_rd_sel", 32'(rd_sel), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        reset = 1'b1;
        expect_pass("resync", 0, exp_bank);
        expect_quiet("resync_quiet", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
